svc_sram_cmd_arb: RTL
=====================

Name: svc_sram_cmd_arb

Overview:
Arbiter between the read-side and write-side SRAM command streams produced by the AXI-to-SRAM read and write converters. It shares the single SRAM command port between the two streams. It uses a sticky round-robin policy with a bounded burst length, which limits read/write turnarounds while guaranteeing that neither side starves. The output is registered, so the SRAM command port is driven directly from flops and accepts one command per cycle at full throughput.

Parameters:
ADDR_WIDTH, 16, SRAM word address width
DATA_WIDTH, 16, SRAM data width
ID_WIDTH, 4, read transaction id width
STRB_WIDTH, DATA_WIDTH/8, write byte-strobe width
MAX_BURST, 4, max consecutive grants to one side while the other side waits; must be >= 1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_cmd_valid  in  1  write command valid
wr_cmd_ready  out  1  write command accepted this cycle
wr_cmd_addr  in  ADDR_WIDTH  write word address
wr_cmd_data  in  DATA_WIDTH  write data
wr_cmd_strb  in  STRB_WIDTH  write byte strobes
rd_cmd_valid  in  1  read command valid
rd_cmd_ready  out  1  read command accepted this cycle
rd_cmd_id  in  ID_WIDTH  read id
rd_cmd_addr  in  ADDR_WIDTH  read word address
sram_cmd_valid  out  1  SRAM command valid (registered)
sram_cmd_ready  in  1  SRAM accepts command
sram_cmd_id  out  ID_WIDTH  read id; 0 on writes
sram_cmd_addr  out  ADDR_WIDTH  word address
sram_cmd_wr_en  out  1  1 = write, 0 = read
sram_cmd_wr_data  out  DATA_WIDTH  write data; 0 on reads
sram_cmd_wr_strb  out  STRB_WIDTH  write strobes; 0 on reads

Behaviour:
- Reset (rst=1 at a clock edge):
  - sram_cmd_valid=0, id/addr/wr_en/wr_data/wr_strb=0.
  - last_grant=RD, burst_cnt=0.
  - Reset overrides any in-flight command; the pending output command is discarded.
- out_free = !sram_cmd_valid || sram_cmd_ready (combinational).
- Arbitration is combinational and evaluated only when out_free=1; otherwise both readys are 0.
  - Neither valid: no grant.
  - Only one side valid: grant that side.
  - Both valid and burst_cnt < MAX_BURST: grant last_grant.
  - Both valid and burst_cnt >= MAX_BURST: grant the other side.
- wr_cmd_ready / rd_cmd_ready = granted side only, never both.
  - Ready may depend combinationally on the other side's valid and on sram_cmd_ready.
  - Ready never depends on the same side's payload.
- On a grant (valid && ready of a side) at a clock edge:
  - Output registers load that side's command; sram_cmd_valid=1 next cycle.
  - Latency is exactly 1 cycle from acceptance to sram_cmd_valid.
  - Granted side == last_grant: burst_cnt = min(burst_cnt+1, MAX_BURST).
  - Otherwise: last_grant = granted side, burst_cnt = 1.
- No grant and sram_cmd_ready=1: sram_cmd_valid clears. burst_cnt and last_grant are held; idle cycles do not reset the burst.
- Stability: while sram_cmd_valid=1 && sram_cmd_ready=0, all sram_cmd_* outputs hold.
- Back-to-back: a new grant in the same cycle that sram_cmd_ready=1 replaces the output. Sustained throughput is 1 command per cycle.
- Starvation bound: while the other side stays valid, a waiting side is granted within MAX_BURST accepted commands.
- Upstream valids follow valid/ready rules (no drop before accept). The arbiter does not depend on this for safety.

Test Plan:
- Reset, then single write (addr=0x0010, data=0xBEEF, strb=2'b11), sram_cmd_ready=1 -> wr_cmd_ready=1 in cycle 0. Cycle 1: sram_cmd_valid=1, wr_en=1, addr=0x0010, data=0xBEEF, id=0. Cycle 2: valid=0.
- Single read (id=4'h5, addr=0x0020) with sram_cmd_ready=0 for 3 cycles -> outputs hold valid=1, wr_en=0, id=5, addr=0x0020, wr_data=0, wr_strb=0. rd_cmd_ready=0 for any new read during the stall.
- After reset, rd and wr both valid continuously, sram_cmd_ready=1, MAX_BURST=4 -> grant sequence R,R,R,R,W,W,W,W,R,... and exactly one ready per cycle.
- Both valid, 2 reads granted; read side drops valid for 2 cycles, then both valid again -> writes granted until 4 consecutive writes; idle cycles do not reset burst_cnt.
- Continuous writes with sram_cmd_ready=1 -> one command per cycle, no bubbles, addresses in order 0x0..0x7.
- Assert rst while sram_cmd_valid=1 and stalled -> next cycle valid=0, all outputs 0. First contended grant after reset goes to read.

Source files
------------

// File: rtl/svc_sram_cmd_arb.sv
// svc_sram_cmd_arb
// Shares one SRAM command port between a read command stream and a write
// command stream. Sticky round-robin with a bounded burst: the side that won
// last keeps winning while it stays valid, until it has taken MAX_BURST
// grants in a row with the other side waiting. The SRAM command port is
// driven straight from flops.
//
// Handshake rule, all three ports: a transfer happens on a rising edge where
// valid && ready are both 1. A source holds valid and its payload stable
// until accepted. Ready may depend on the other side's valid and on
// downstream ready, but never on the same side's payload. The output holds
// every field while sram_cmd_valid && !sram_cmd_ready.

module svc_sram_cmd_arb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [DATA_WIDTH-1:0] wr_cmd_data,
  input  logic [STRB_WIDTH-1:0] wr_cmd_strb,

  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [ID_WIDTH-1:0]   rd_cmd_id,
  input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,

  output logic                  sram_cmd_valid,
  input  logic                  sram_cmd_ready,
  output logic [ID_WIDTH-1:0]   sram_cmd_id,
  output logic [ADDR_WIDTH-1:0] sram_cmd_addr,
  output logic                  sram_cmd_wr_en,
  output logic [DATA_WIDTH-1:0] sram_cmd_wr_data,
  output logic [STRB_WIDTH-1:0] sram_cmd_wr_strb
);

  // Which side owns the current burst.
  typedef enum logic {
    SIDE_RD = 1'b0,
    SIDE_WR = 1'b1
  } side_e;

  // The burst counter saturates at MAX_BURST, so it needs to hold that value.
  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  side_e            last_grant_q;
  side_e            last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_d;

  logic             out_free;
  logic             grant_wr;
  logic             grant_rd;
  logic             any_grant;
  side_e            grant_side;

  // The output slot can take a new command when empty or draining this cycle.
  assign out_free = !sram_cmd_valid || sram_cmd_ready;

  // Arbitration: sticky to the last winner until its burst budget is spent.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (out_free) begin
      if (wr_cmd_valid && rd_cmd_valid) begin
        if (burst_cnt_q < CNT_MAX) begin
          if (last_grant_q == SIDE_WR) begin
            grant_wr = 1'b1;
          end else begin
            grant_rd = 1'b1;
          end
        end else begin
          if (last_grant_q == SIDE_WR) begin
            grant_rd = 1'b1;
          end else begin
            grant_wr = 1'b1;
          end
        end
      end else if (wr_cmd_valid) begin
        grant_wr = 1'b1;
      end else if (rd_cmd_valid) begin
        grant_rd = 1'b1;
      end
    end
  end

  // A grant is only ever issued to a valid side, so ready == grant.
  assign wr_cmd_ready = grant_wr;
  assign rd_cmd_ready = grant_rd;
  assign any_grant    = grant_wr || grant_rd;
  assign grant_side   = grant_wr ? SIDE_WR : SIDE_RD;

  // Burst bookkeeping: extend the run on a repeat winner, restart on a switch.
  // Idle cycles leave both fields untouched.
  always_comb begin
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    if (any_grant) begin
      if (grant_side == last_grant_q) begin
        if (burst_cnt_q >= CNT_MAX) begin
          burst_cnt_d = CNT_MAX;
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_ONE;
        end
      end else begin
        last_grant_d = grant_side;
        burst_cnt_d  = CNT_ONE;
      end
    end
  end

  // Arbitration state register; reset favours the read side first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SIDE_RD;
      burst_cnt_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Output command register: load the winner, drain on downstream accept,
  // otherwise hold. Reads carry zero data/strobes, writes carry zero id.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_cmd_valid   <= 1'b0;
      sram_cmd_id      <= '0;
      sram_cmd_addr    <= '0;
      sram_cmd_wr_en   <= 1'b0;
      sram_cmd_wr_data <= '0;
      sram_cmd_wr_strb <= '0;
    end else if (grant_wr) begin
      sram_cmd_valid   <= 1'b1;
      sram_cmd_id      <= '0;
      sram_cmd_addr    <= wr_cmd_addr;
      sram_cmd_wr_en   <= 1'b1;
      sram_cmd_wr_data <= wr_cmd_data;
      sram_cmd_wr_strb <= wr_cmd_strb;
    end else if (grant_rd) begin
      sram_cmd_valid   <= 1'b1;
      sram_cmd_id      <= rd_cmd_id;
      sram_cmd_addr    <= rd_cmd_addr;
      sram_cmd_wr_en   <= 1'b0;
      sram_cmd_wr_data <= '0;
      sram_cmd_wr_strb <= '0;
    end else if (sram_cmd_ready) begin
      sram_cmd_valid   <= 1'b0;
    end
  end

endmodule
